// File: rtl/conc_stim_pkg.sv
// conc_stim_pkg
// Shared definitions for the stimulus player slice: the playback state
// encoding and the layout of one vector-memory entry.
// An entry is DATA_W+1 bits wide: the data word occupies the low DATA_W
// bits and the observation flag sits directly above it.
package conc_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Lowest bit of the data field inside an entry.
    localparam int unsigned ENTRY_DATA_LSB = 0;

    // Offset of the obs flag above the data field (obs index = DATA_W + offset).
    localparam int unsigned ENTRY_OBS_OFS = 0;

    // Bit index of the obs flag for a given data width.
    function automatic int unsigned entry_obs_idx(input int unsigned data_w);
        return data_w + ENTRY_OBS_OFS;
    endfunction

endpackage

// File: rtl/conc_stim_player_if.sv
// conc_stim_player_if
// Bundles the vector-load port, the playback controls and the replayed
// outputs of conc_stim_player.
//   master : drives wr_en/wr_addr/wr_data, last_addr, start, hold (and loop)
//            and observes data_o, obs_o, pc_o, busy, done
//   slave  : the player side (mirror image of master)
// Optional: CONC_STIM_LOOP_EN adds the loop control signal.
interface conc_stim_player_if #(
    parameter int unsigned DATA_W = 31,
    parameter int unsigned AW     = 5
);
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W:0]   wr_data;
    logic [AW-1:0]     last_addr;
    logic              start;
    logic              hold;
`ifdef CONC_STIM_LOOP_EN
    logic              loop;
`endif
    logic [DATA_W-1:0] data_o;
    logic              obs_o;
    logic [AW-1:0]     pc_o;
    logic              busy;
    logic              done;

    modport master (
        output wr_en, wr_addr, wr_data, last_addr, start, hold,
`ifdef CONC_STIM_LOOP_EN
        output loop,
`endif
        input  data_o, obs_o, pc_o, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, last_addr, start, hold,
`ifdef CONC_STIM_LOOP_EN
        input  loop,
`endif
        output data_o, obs_o, pc_o, busy, done
    );

endinterface

// File: rtl/conc_stim_ram.sv
// conc_stim_ram
// DEPTH x (DATA_W+1) vector store, one synchronous write port and one
// combinational read port. Contents are not reset.
//   clock   : write clock
//   wr_en   : write strobe
//   wr_addr : write index
//   wr_data : entry written
//   rd_addr : read index
//   rd_data : entry at rd_addr (pre-write contents on a same-edge write)
module conc_stim_ram #(
    parameter int unsigned DATA_W = 31,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DATA_W:0] wr_data,
    input  logic [AW-1:0]   rd_addr,
    output logic [DATA_W:0] rd_data
);

    logic [DATA_W:0] mem_r [DEPTH];

    // Vector load; storage deliberately has no reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read; the player registers it, so a write on the same
    // edge is seen only afterwards.
    always_comb begin
        rd_data = mem_r[rd_addr];
    end

endmodule

// File: rtl/conc_stim_player.sv
// conc_stim_player
// Replays vectors from an internal store: after start, one entry per clock
// (stalled by hold) is registered onto {obs_o, data_o} until the entry at
// last_addr has been emitted; done then pulses for one cycle.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : conc_stim_player_if.slave (load port, controls, outputs)
// Optional: define CONC_STIM_LOOP_EN to add bus.loop, which restarts at
// entry 0 after last_addr instead of finishing.
module conc_stim_player
    import conc_stim_pkg::*;
#(
    parameter int unsigned DATA_W = 31,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    conc_stim_player_if.slave   bus
);

    localparam int unsigned OBS_IDX = entry_obs_idx(DATA_W);

    state_e            state_r, state_n;
    logic [AW-1:0]     pc_r, pc_n, pc_inc_s;
    logic [DATA_W-1:0] data_r, data_n;
    logic              obs_r, obs_n;
    logic              busy_r, busy_n;
    logic              done_r, done_n;
    logic [DATA_W:0]   rd_entry_s;
    logic              loop_s;

    conc_stim_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clock   (clock),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (pc_r),
        .rd_data (rd_entry_s)
    );

    // Loop request exists only in the looping build.
    always_comb begin
`ifdef CONC_STIM_LOOP_EN
        loop_s = bus.loop;
`else
        loop_s = 1'b0;
`endif
    end

    // Next pc, wrapping explicitly so non-power-of-two depths stay in range.
    always_comb begin
        if (pc_r == AW'(DEPTH - 1)) begin
            pc_inc_s = {AW{1'b0}};
        end else begin
            pc_inc_s = pc_r + AW'(1);
        end
    end

    // Playback FSM next-state and next-output logic.
    always_comb begin
        state_n = state_r;
        pc_n    = pc_r;
        data_n  = data_r;
        obs_n   = obs_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_n = PLAY;
                    pc_n    = {AW{1'b0}};
                end else begin
                    state_n = IDLE;
                end
            end
            PLAY: begin
                if (bus.hold) begin
                    state_n = PLAY;
                end else begin
                    data_n = rd_entry_s[ENTRY_DATA_LSB +: DATA_W];
                    obs_n  = rd_entry_s[OBS_IDX];
                    // last_addr is compared live so a mid-run change applies at once.
                    if (pc_r == bus.last_addr) begin
                        if (loop_s) begin
                            pc_n = {AW{1'b0}};
                        end else begin
                            pc_n    = pc_inc_s;
                            state_n = DONE;
                        end
                    end else begin
                        pc_n = pc_inc_s;
                    end
                end
            end
            DONE: begin
                // start is deliberately not looked at here.
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n == PLAY);
        done_n = (state_n == DONE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            pc_r    <= {AW{1'b0}};
            data_r  <= {DATA_W{1'b0}};
            obs_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            pc_r    <= pc_n;
            data_r  <= data_n;
            obs_r   <= obs_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
        end
    end

    assign bus.data_o = data_r;
    assign bus.obs_o  = obs_r;
    assign bus.pc_o   = pc_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;

endmodule

// File: doc/conc_stim_player.md
CONC_STIM_PLAYER -- requirements
Module: conc_stim_player

Interface
REQ-001 SHALL have parameter DATA_W, default 31, width of the replayed data word.
REQ-002 SHALL have parameter DEPTH, default 32, number of vector entries; DEPTH >= 2.
REQ-003 SHALL have parameter AW, default $clog2(DEPTH), entry-address width.
REQ-004 SHALL have port clock, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port wr_en, input, 1, vector-load write strobe.
REQ-007 SHALL have port wr_addr, input, AW, entry index being loaded.
REQ-008 SHALL have port wr_data, input, DATA_W+1, entry with bit DATA_W = obs and bits DATA_W-1:0 = data.
REQ-009 SHALL have port last_addr, input, AW, index of the final entry played.
REQ-010 SHALL have port start, input, 1, begin playback.
REQ-011 SHALL have port hold, input, 1, stall playback.
REQ-012 SHALL have port loop, input, 1, restart at entry 0 after last_addr; present only with CONC_STIM_LOOP_EN.
REQ-013 SHALL have port data_o, output, DATA_W, replayed data word.
REQ-014 SHALL have port obs_o, output, 1, replayed observation bit.
REQ-015 SHALL have port pc_o, output, AW, index of the next entry to be emitted.
REQ-016 SHALL have port busy, output, 1, high in PLAY.
REQ-017 SHALL have port done, output, 1, one-cycle pulse at end of playback.

Function
REQ-018 SHALL implement states IDLE, PLAY and DONE.
REQ-019 In IDLE, start=1 SHALL set pc to 0 and move to PLAY.
REQ-020 In PLAY with hold=0, each edge SHALL register mem[pc] into {obs_o,data_o} and advance pc by 1.
REQ-021 With start sampled at edge k, mem[0] SHALL appear on the outputs after edge k+1, giving one-cycle latency.
REQ-022 In PLAY with hold=1, pc and all outputs SHALL be held unchanged.
REQ-023 The edge emitting mem[last_addr] SHALL move the state to DONE, or, with loop=1, set pc to 0 and remain in PLAY without a gap.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-025 data_o and obs_o SHALL keep the last emitted value while in DONE and IDLE.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 start=1 in the DONE cycle SHALL NOT restart playback.
REQ-028 Writes SHALL be accepted in any state.
REQ-029 A write and a read of the same address on the same edge SHALL return the old contents.
REQ-030 pc SHALL wrap from DEPTH-1 to 0 when last_addr = DEPTH-1.
REQ-031 last_addr = 0 SHALL play exactly one entry.
REQ-032 last_addr SHALL be sampled on every PLAY edge; changing it mid-playback takes effect immediately.

Reset
REQ-033 Asserting reset low SHALL immediately force IDLE, pc_o=0, data_o=0, obs_o=0, busy=0 and done=0, including mid-playback.
REQ-034 Vector memory contents SHALL NOT be reset and are undefined until written.

Configuration
REQ-035 Macro CONC_STIM_LOOP_EN defined: the loop port SHALL exist and REQ-023 loop behaviour SHALL apply.
REQ-036 Macro CONC_STIM_LOOP_EN undefined: the loop port SHALL be absent and playback SHALL always end in DONE after last_addr.

Structure
REQ-037 Shared package conc_stim_pkg SHALL hold the state enum (IDLE/PLAY/DONE) and the entry-field index constants.
REQ-038 Sub-module conc_stim_ram SHALL implement the DEPTH x (DATA_W+1) store with one write port and one combinational read port; player FSM in conc_stim_player.

Verification
REQ-039 Load entries 0..3 = {1,31'h1},{0,31'h2},{1,31'h3},{0,31'h4}, set last_addr=3, pulse start -> outputs 0x1/1, 0x2/0, 0x3/1, 0x4/0 on consecutive edges; done=1 one cycle after 0x4; busy high 4 cycles.
REQ-040 Same load, hold=1 for 2 cycles after 0x2 -> 0x2 held 3 cycles, pc_o=2 throughout, no entry skipped.
REQ-041 With CONC_STIM_LOOP_EN, loop=1, last_addr=1 -> sequence 0x1,0x2,0x1,0x2... with done never asserted; clearing loop ends playback after the next 0x2.
REQ-042 reset driven low while pc_o=2 -> all outputs 0 and state IDLE without waiting for a clock edge; a subsequent start replays from entry 0.
REQ-043 Write entry 1 = 31'h55 on the edge that reads entry 1 -> emits old 0x2; replay after done emits 0x55.
REQ-044 last_addr=0 with start -> exactly one vector emitted and done pulses on the following cycle.
